sum_accumulator: RTL and testbench

//  Result stage directly downstream of the 4-bit parallel adder (pa).
//  - Consumes each adder result {Cout,S} as a 5-bit unsigned term.
//  - Accumulates N_TERMS terms into a wider register.
//  - Presents the total on a valid/ready output handshake with a sticky overflow flag.

---
 rtl/sum_acc_pkg.sv | 12 +
 rtl/acc_add_sat.sv | 26 ++
 rtl/sum_accumulator.sv | 105 ++++++++++
 tb/tb_sum_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared types and constants for the adder result accumulator
package sum_acc_pkg;

  localparam int TERM_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_add_sat.sv
// rtl/acc_add_sat.sv - accumulator adder with overflow detect
// SUM_ACC_SATURATE_EN defined: clamp to all-ones on overflow; undefined: wrap.
module acc_add_sat
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [TERM_W-1:0] term_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc_i} + {{(ACC_W + 1 - TERM_W){1'b0}}, term_i};
  assign ovf_o = sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
  // A clamped acc plus any nonzero term overflows again, so it stays clamped.
  assign acc_o = ovf_o ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_o = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates N_TERMS adder results, presents total on valid/ready
// Overflow behaviour selected by SUM_ACC_SATURATE_EN inside acc_add_sat.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [TERM_W-1:0] term;
  logic [ACC_W-1:0]  add_base;
  logic [ACC_W-1:0]  add_acc;
  logic              add_ovf;
  logic              accept;
  logic              deliver;

  assign term    = {in_cout, in_sum};
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // The first term of a batch replaces whatever total was left from the last one.
  assign add_base = (state_q == IDLE) ? '0 : acc_q;

  acc_add_sat #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (add_base),
    .term_i (term),
    .acc_o  (add_acc),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = add_acc;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (N_TERMS == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_acc;
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (deliver) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard bench for sum_accumulator (ACC_W=8 and ACC_W=6 instances)
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_sum;
  logic       in_cout;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_ovf8;
  logic [7:0] out_acc8;
  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_acc6;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp8_q[$];
  logic [6:0] exp6_q[$];
  logic [8:0] e8;
  logic [6:0] e6;

`ifdef SUM_ACC_SATURATE_EN
  localparam logic [5:0] OVF6_ACC = 6'd63;
`else
  localparam logic [5:0] OVF6_ACC = 6'd60;
`endif

  always #5 clk = ~clk;

  sum_accumulator #(.ACC_W(8), .N_TERMS(4)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_acc   (out_acc8),
    .out_ovf   (out_ovf8)
  );

  sum_accumulator #(.ACC_W(6), .N_TERMS(4)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .out_acc   (out_acc6),
    .out_ovf   (out_ovf6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_batch(input logic [8:0] r8, input logic [6:0] r6);
    exp8_q.push_back(r8);
    exp6_q.push_back(r6);
  endtask

  task automatic push_term(input logic [4:0] t);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    {in_cout, in_sum} = t;
    while (!in_ready8 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready8) begin
      chk("in_ready_timeout", 32'(in_ready8), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid8"}, 32'(out_valid8), 32'd0);
    chk({tag, "_in_ready8"},  32'(in_ready8),  32'd1);
    chk({tag, "_out_valid6"}, 32'(out_valid6), 32'd0);
    chk({tag, "_in_ready6"},  32'(in_ready6),  32'd1);
  endtask

  // Scoreboard side: every delivered result is matched against the next expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready) begin
      if (exp8_q.size() == 0) begin
        chk("acc8_unexpected_result", 32'(out_acc8), 32'hFFFF_FFFF);
      end else begin
        e8 = exp8_q.pop_front();
        chk("acc8_total", 32'(out_acc8), 32'(e8[7:0]));
        chk("acc8_ovf",   32'(out_ovf8), 32'(e8[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid6 && out_ready) begin
      if (exp6_q.size() == 0) begin
        chk("acc6_unexpected_result", 32'(out_acc6), 32'hFFFF_FFFF);
      end else begin
        e6 = exp6_q.pop_front();
        chk("acc6_total", 32'(out_acc6), 32'(e6[5:0]));
        chk("acc6_ovf",   32'(out_ovf6), 32'(e6[6]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_sum = 4'd0; in_cout = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_out_acc8", 32'(out_acc8), 32'd0);
    chk("reset_out_ovf8", 32'(out_ovf8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic batch 3+5+7+9 = 24, result visible the cycle after the 4th accept
    expect_batch({1'b0, 8'd24}, {1'b0, 6'd24});
    push_term(5'd3); push_term(5'd5); push_term(5'd7); push_term(5'd9);
    chk("basic_latency_out_valid", 32'(out_valid8), 32'd1);
    chk("basic_hold_in_ready",     32'(in_ready8),  32'd0);
    @(posedge clk); #1;
    check_idle_outputs("basic_after_handshake");

    // Carry terms 31 x4: 124 at ACC_W=8; ACC_W=6 overflows (wrap 60 / clamp 63)
    expect_batch({1'b0, 8'd124}, {1'b1, OVF6_ACC});
    repeat (4) push_term(5'd31);
    @(posedge clk); #1;

    // Backpressure: 8 x4 = 32, held three cycles while in_valid pulses are ignored
    out_ready = 1'b0;
    expect_batch({1'b0, 8'd32}, {1'b0, 6'd32});
    repeat (4) push_term(5'd8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; {in_cout, in_sum} = 5'd31;
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
      chk("bp_in_ready",  32'(in_ready8),  32'd0);
      chk("bp_out_acc8",  32'(out_acc8),   32'd32);
      chk("bp_out_ovf8",  32'(out_ovf8),   32'd0);
      chk("bp_out_acc6",  32'(out_acc6),   32'd32);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("bp_release");

    // Gaps then clear (with a term offered in the clear cycle), then 1 x4 = 4
    push_term(5'd2);
    @(posedge clk); #1;
    push_term(5'd2);
    in_valid = 1'b1; {in_cout, in_sum} = 5'd5; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    check_idle_outputs("clear");
    chk("clear_out_acc8", 32'(out_acc8), 32'd0);
    expect_batch({1'b0, 8'd4}, {1'b0, 6'd4});
    repeat (4) push_term(5'd1);
    @(posedge clk); #1;

    // Reset after 3 accepts, then 10 x4 = 40
    repeat (3) push_term(5'd10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_outputs("midreset");
    chk("midreset_out_acc8", 32'(out_acc8), 32'd0);
    chk("midreset_out_ovf8", 32'(out_ovf8), 32'd0);
    chk("midreset_out_acc6", 32'(out_acc6), 32'd0);
    expect_batch({1'b0, 8'd40}, {1'b0, 6'd40});
    repeat (4) push_term(5'd10);

    repeat (4) @(posedge clk);
    #1;
    chk("acc8_pending_expectations", 32'(exp8_q.size()), 32'd0);
    chk("acc6_pending_expectations", 32'(exp6_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
